// File: rtl/text_pkg.sv
// Shared constants and types for the UART text buffer.
package text_pkg;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 30;

  localparam logic [7:0] CHR_SPACE     = 8'h20;
  localparam logic [7:0] CHR_CR        = 8'h0D;
  localparam logic [7:0] CHR_LF        = 8'h0A;
  localparam logic [7:0] CHR_BS        = 8'h08;
  localparam logic [7:0] CHR_PRINT_MIN = 8'h20;
  localparam logic [7:0] CHR_PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  // True for bytes that are stored on screen as glyphs.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CHR_PRINT_MIN) && (b <= CHR_PRINT_MAX);
  endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one synchronous write, one registered read.
module text_ram
  import text_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_COLS * DEF_ROWS,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Write port; array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; a same-cycle write to the same cell returns the old data.
  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/uart_text_buffer.sv
// UART byte stream to scrolling text screen with cursor and render read port.
module uart_text_buffer
  import text_pkg::*;
#(
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned ROWS  = DEF_ROWS,
  parameter int unsigned COL_W = $clog2(COLS),
  parameter int unsigned ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             clear,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_char,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned DEPTH  = COLS * ROWS;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned RS_W   = ROW_W + 1;

  // Logical row to physical row with explicit wrap at ROWS.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                input logic [ROW_W-1:0] top);
    logic [RS_W-1:0] s;
    s = {1'b0, lrow} + {1'b0, top};
    if (s >= RS_W'(ROWS)) begin
      s = s - RS_W'(ROWS);
    end
    return s[ROW_W-1:0];
  endfunction

  // Linear RAM address of a physical cell.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_sweep, w_sweep_nx;
  logic [COL_W-1:0]  r_col, w_col_nx;
  logic [ROW_W-1:0]  r_row, w_row_nx;
  logic [ROW_W-1:0]  r_top, w_top_nx;
  logic              r_pend_vld, w_pend_vld_nx;
  logic [7:0]        r_pend, w_pend_nx;
  logic              r_ovf, w_ovf_nx;
  logic              r_busy;
  logic              r_rd_oob;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;
  logic              w_have;
  logic [7:0]        w_byte;
  logic              w_nl;
  logic              w_rd_oob;
  logic [ADDR_W-1:0] w_raddr;
  logic [7:0]        w_ram_q;

  // Render read address; out-of-range requests are forced to a safe address.
  assign w_rd_oob = (rd_col >= COL_W'(COLS)) || (rd_row >= ROW_W'(ROWS));
  assign w_raddr  = w_rd_oob ? '0 : cell_addr(phys_row(rd_row, r_top), rd_col);

  text_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_sweep    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_top      <= '0;
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b1;
      r_rd_oob   <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_sweep    <= w_sweep_nx;
      r_col      <= w_col_nx;
      r_row      <= w_row_nx;
      r_top      <= w_top_nx;
      r_pend_vld <= w_pend_vld_nx;
      r_pend     <= w_pend_nx;
      r_ovf      <= w_ovf_nx;
      r_busy     <= (w_state_nx != ST_IDLE);
      r_rd_oob   <= w_rd_oob;
    end
  end

  // Next-state: input buffering, byte decode, sweeps, clear override.
  always_comb begin
    w_state_nx    = r_state;
    w_sweep_nx    = r_sweep;
    w_col_nx      = r_col;
    w_row_nx      = r_row;
    w_top_nx      = r_top;
    w_pend_vld_nx = r_pend_vld;
    w_pend_nx     = r_pend;
    w_ovf_nx      = r_ovf;
    w_we          = 1'b0;
    w_waddr       = '0;
    w_wdata       = CHR_SPACE;
    w_have        = 1'b0;
    w_byte        = r_pend;
    w_nl          = 1'b0;

    // Bytes that cannot be decoded now go to the single pending slot or are lost.
    if (rx_valid && ((r_state != ST_IDLE) || r_pend_vld)) begin
      if (!r_pend_vld) begin
        w_pend_vld_nx = 1'b1;
        w_pend_nx     = rx_data;
      end else begin
        w_ovf_nx = 1'b1;
      end
    end

    if (r_state == ST_IDLE) begin
      if (r_pend_vld) begin
        w_have        = 1'b1;
        w_byte        = r_pend;
        w_pend_vld_nx = 1'b0;
      end else if (rx_valid) begin
        w_have = 1'b1;
        w_byte = rx_data;
      end
    end

    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_sweep;
        if (r_sweep == ADDR_W'(DEPTH - 1)) begin
          w_state_nx = ST_IDLE;
          w_sweep_nx = '0;
        end else begin
          w_sweep_nx = r_sweep + ADDR_W'(1);
        end
      end

      ST_SCROLL: begin
        w_we    = 1'b1;
        w_waddr = cell_addr(phys_row(ROW_W'(ROWS - 1), r_top), COL_W'(r_sweep));
        if (r_sweep == ADDR_W'(COLS - 1)) begin
          w_state_nx = ST_IDLE;
          w_sweep_nx = '0;
        end else begin
          w_sweep_nx = r_sweep + ADDR_W'(1);
        end
      end

      ST_IDLE: begin
        if (w_have) begin
          if (is_printable(w_byte)) begin
            w_we    = 1'b1;
            w_waddr = cell_addr(phys_row(r_row, r_top), r_col);
            w_wdata = w_byte;
            if (r_col == COL_W'(COLS - 1)) begin
              w_col_nx = '0;
              w_nl     = 1'b1;
            end else begin
              w_col_nx = r_col + COL_W'(1);
            end
          end else if (w_byte == CHR_CR) begin
            w_col_nx = '0;
          end else if (w_byte == CHR_LF) begin
            w_col_nx = '0;
            w_nl     = 1'b1;
          end else if (w_byte == CHR_BS) begin
            if (r_col != '0) begin
              w_col_nx = r_col - COL_W'(1);
              w_we     = 1'b1;
              w_waddr  = cell_addr(phys_row(r_row, r_top), r_col - COL_W'(1));
              w_wdata  = CHR_SPACE;
            end
          end
        end
        // Newline on the bottom row scrolls instead of moving the cursor.
        if (w_nl) begin
          if (r_row != ROW_W'(ROWS - 1)) begin
            w_row_nx = r_row + ROW_W'(1);
          end else begin
            w_top_nx   = (r_top == ROW_W'(ROWS - 1)) ? '0 : r_top + ROW_W'(1);
            w_state_nx = ST_SCROLL;
            w_sweep_nx = '0;
          end
        end
      end

      default: begin
        w_state_nx = ST_CLEAR;
        w_sweep_nx = '0;
      end
    endcase

    if (clear) begin
      w_state_nx    = ST_CLEAR;
      w_sweep_nx    = '0;
      w_col_nx      = '0;
      w_row_nx      = '0;
      w_top_nx      = '0;
      w_pend_vld_nx = 1'b0;
      w_ovf_nx      = 1'b0;
      w_we          = 1'b0;
    end
  end

  assign rd_char    = r_rd_oob ? CHR_SPACE : w_ram_q;
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign busy       = r_busy;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_text_buffer.sv
// Self-checking bench for uart_text_buffer with a cell-expectation scoreboard.
module tb_uart_text_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       clear;
  logic [6:0] rd_col;
  logic [4:0] rd_row;
  logic [7:0] rd_char;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] ch;
  } exp_t;

  exp_t sb[$];

  uart_text_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .clear      (clear),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] ch);
    rd_row = 5'(r);
    rd_col = 7'(c);
    @(posedge clk); #1;
    ch = rd_char;
  endtask

  task automatic push_exp(input int r, input int c, input logic [7:0] ch);
    exp_t e;
    e.row = r;
    e.col = c;
    e.ch  = ch;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_clear(input string tag);
    int cyc;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_idle(3000, cyc);
    n_tests++;
    if (cyc != 2400) begin
      n_fail++;
      $display("FAIL %s clear_busy_cycles: got %0d expected 2400", tag, cyc);
    end
  endtask

  task automatic test_reset;
    int   cyc;
    int   bad;
    logic [7:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (rd_char !== 8'h20 || busy !== 1'b1 || overflow !== 1'b0 ||
        cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: rd_char=%h busy=%b ovf=%b cur=%0d/%0d expected 20 1 0 0/0",
               rd_char, busy, overflow, cursor_row, cursor_col);
    end
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle(3000, cyc);
    n_tests++;
    if (cyc != 2400) begin
      n_fail++;
      $display("FAIL reset_busy_cycles: got %0d expected 2400", cyc);
    end
    bad = 0;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 80; c++) begin
        read_cell(r, c, got);
        if (got !== 8'h20) bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_blank_screen: %0d cells not 20, expected 0", bad);
    end
    n_tests++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cursor: got %0d/%0d ovf=%b expected 0/0 0", cursor_row, cursor_col, overflow);
    end
  endtask

  task automatic test_ab;
    exp_t e;
    logic [7:0] got;
    send_byte(8'h41);
    send_byte(8'h42);
    push_exp(0, 0, 8'h41);
    push_exp(0, 1, 8'h42);
    n_tests++;
    if (cursor_col !== 7'd2 || cursor_row !== 5'd0) begin
      n_fail++;
      $display("FAIL ab_cursor: got %0d/%0d expected 0/2", cursor_row, cursor_col);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.row, e.col, got);
      n_tests++;
      if (got !== e.ch) begin
        n_fail++;
        $display("FAIL ab_cell(%0d,%0d): got %h expected %h", e.row, e.col, got, e.ch);
      end
    end
    // Output must hold the previous read until the next edge.
    read_cell(0, 0, got);
    rd_col = 7'd1;
    #3;
    n_tests++;
    if (rd_char !== 8'h41) begin
      n_fail++;
      $display("FAIL ab_read_latency: got %h expected 41", rd_char);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rd_char !== 8'h42) begin
      n_fail++;
      $display("FAIL ab_read_next: got %h expected 42", rd_char);
    end
  endtask

  task automatic test_backspace;
    exp_t e;
    logic [7:0] got;
    do_clear("bs");
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    send_byte(8'h08);
    push_exp(0, 0, 8'h41);
    push_exp(0, 1, 8'h42);
    push_exp(0, 2, 8'h20);
    n_tests++;
    if (cursor_col !== 7'd2 || cursor_row !== 5'd0) begin
      n_fail++;
      $display("FAIL bs_cursor: got %0d/%0d expected 0/2", cursor_row, cursor_col);
    end
    send_byte(8'h0D);
    send_byte(8'h08);
    push_exp(0, 0, 8'h41);
    n_tests++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      n_fail++;
      $display("FAIL bs_col0_cursor: got %0d/%0d expected 0/0", cursor_row, cursor_col);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.row, e.col, got);
      n_tests++;
      if (got !== e.ch) begin
        n_fail++;
        $display("FAIL bs_cell(%0d,%0d): got %h expected %h", e.row, e.col, got, e.ch);
      end
    end
  endtask

  task automatic test_scroll;
    exp_t e;
    int   cyc;
    logic [7:0] got;
    do_clear("scroll");
    for (int i = 0; i < 30; i++) begin
      send_byte(8'(8'h41 + i));
      send_byte(8'h0A);
    end
    wait_idle(200, cyc);
    n_tests++;
    if (cyc != 80) begin
      n_fail++;
      $display("FAIL scroll_busy_cycles: got %0d expected 80", cyc);
    end
    n_tests++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd29) begin
      n_fail++;
      $display("FAIL scroll_cursor: got %0d/%0d expected 29/0", cursor_row, cursor_col);
    end
    for (int r = 0; r < 29; r++) push_exp(r, 0, 8'(8'h42 + r));
    push_exp(29, 0, 8'h20);
    push_exp(29, 79, 8'h20);
    push_exp(0, 1, 8'h20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.row, e.col, got);
      n_tests++;
      if (got !== e.ch) begin
        n_fail++;
        $display("FAIL scroll_cell(%0d,%0d): got %h expected %h", e.row, e.col, got, e.ch);
      end
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    logic [7:0] got;
    do_clear("wrap");
    for (int i = 0; i < 81; i++) begin
      send_byte(8'(8'h21 + i));
      if (i < 80) push_exp(0, i, 8'(8'h21 + i));
      else        push_exp(1, 0, 8'(8'h21 + i));
    end
    push_exp(1, 1, 8'h20);
    n_tests++;
    if (cursor_col !== 7'd1 || cursor_row !== 5'd1) begin
      n_fail++;
      $display("FAIL wrap_cursor: got %0d/%0d expected 1/1", cursor_row, cursor_col);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.row, e.col, got);
      n_tests++;
      if (got !== e.ch) begin
        n_fail++;
        $display("FAIL wrap_cell(%0d,%0d): got %h expected %h", e.row, e.col, got, e.ch);
      end
    end
    // Out-of-range reads that would otherwise alias written cells.
    read_cell(0, 80, got);
    n_tests++;
    if (got !== 8'h20) begin
      n_fail++;
      $display("FAIL wrap_oob_col: got %h expected 20", got);
    end
    read_cell(30, 0, got);
    n_tests++;
    if (got !== 8'h20) begin
      n_fail++;
      $display("FAIL wrap_oob_row: got %h expected 20", got);
    end
  endtask

  task automatic test_overflow;
    exp_t e;
    int   cyc;
    logic [7:0] got;
    do_clear("ovf");
    for (int i = 0; i < 30; i++) send_byte(8'h0A);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_scroll_started: busy=%b expected 1", busy);
    end
    send_byte(8'h50);
    send_byte(8'h51);
    send_byte(8'h52);
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag_set: got %b expected 1", overflow);
    end
    wait_idle(200, cyc);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_scroll_timeout: busy=%b expected 0", busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (cursor_col !== 7'd1 || cursor_row !== 5'd29) begin
      n_fail++;
      $display("FAIL ovf_cursor: got %0d/%0d expected 29/1", cursor_row, cursor_col);
    end
    push_exp(29, 0, 8'h50);
    push_exp(29, 1, 8'h20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.row, e.col, got);
      n_tests++;
      if (got !== e.ch) begin
        n_fail++;
        $display("FAIL ovf_cell(%0d,%0d): got %h expected %h", e.row, e.col, got, e.ch);
      end
    end
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    // Clear wins over a same-cycle byte.
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    clear    = 1'b0;
    n_tests++;
    if (overflow !== 1'b0 || busy !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      n_fail++;
      $display("FAIL ovf_clear_state: ovf=%b busy=%b cur=%0d/%0d expected 0 1 0/0",
               overflow, busy, cursor_row, cursor_col);
    end
    wait_idle(3000, cyc);
    n_tests++;
    if (cyc != 2400) begin
      n_fail++;
      $display("FAIL ovf_clear_busy_cycles: got %0d expected 2400", cyc);
    end
    push_exp(0, 0, 8'h20);
    push_exp(29, 0, 8'h20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.row, e.col, got);
      n_tests++;
      if (got !== e.ch) begin
        n_fail++;
        $display("FAIL ovf_clear_cell(%0d,%0d): got %h expected %h", e.row, e.col, got, e.ch);
      end
    end
    n_tests++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear_final: cur=%0d/%0d ovf=%b expected 0/0 0",
               cursor_row, cursor_col, overflow);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    clear    = 1'b0;
    rd_col   = 7'd0;
    rd_row   = 5'd0;
    test_reset();
    test_ab();
    test_backspace();
    test_scroll();
    test_wrap();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
